// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus types and helpers.
// Used by the bus arbiter and its round-robin grant logic.
package rggen_rtl_pkg;

    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_direction;

    typedef enum logic [1:0] {
        RGGEN_OKAY   = 2'b00,
        RGGEN_EXOKAY = 2'b01,
        RGGEN_SLVERR = 2'b10,
        RGGEN_DECERR = 2'b11
    } rggen_status;

    // Index width that never collapses to zero bits (a single requester still needs one bit).
    function automatic int rggen_clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/rggen_round_robin_arbiter.sv
// Combinational round-robin pick: the first requester at or after the pointer wins,
// wrapping from NUM_REQUESTERS-1 back to 0.
module rggen_round_robin_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int NUM_REQUESTERS = 2,
    parameter int INDEX_WIDTH    = rggen_clog2_min1(NUM_REQUESTERS)
)(
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic [INDEX_WIDTH-1:0]    pointer,
    output logic                      grant_valid,
    output logic [NUM_REQUESTERS-1:0] grant_onehot,
    output logic [INDEX_WIDTH-1:0]    grant_index
);

    // candidate_index[gi] is the requester examined at priority position gi
    logic [INDEX_WIDTH-1:0] candidate_index [NUM_REQUESTERS];

    generate
        for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_candidate
            assign candidate_index[gi] = INDEX_WIDTH'((int'(pointer) + gi) % NUM_REQUESTERS);
        end
    endgenerate

    always_comb begin
        grant_valid  = 1'b0;
        grant_index  = '0;
        grant_onehot = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (!grant_valid && request[candidate_index[i]]) begin
                grant_valid = 1'b1;
                grant_index = candidate_index[i];
            end
        end
        if (grant_valid) begin
            grant_onehot[grant_index] = 1'b1;
        end
    end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Shares one local register bus between NUM_REQUESTERS hosts: round-robin grant,
// one access in flight, payload captured at grant, optional watchdog on hung accesses.
module rggen_bus_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int NUM_REQUESTERS      = 2,
    parameter int LOCAL_ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH          = 32,
    parameter int TIMEOUT_CYCLES      = 0
)(
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [NUM_REQUESTERS-1:0]                          i_request,
    input  rggen_direction [NUM_REQUESTERS-1:0]                i_direction,
    input  logic [NUM_REQUESTERS-1:0][LOCAL_ADDRESS_WIDTH-1:0] i_address,
    input  logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0]          i_write_data,
    input  logic [NUM_REQUESTERS-1:0][DATA_WIDTH/8-1:0]        i_write_strobe,
    output logic [NUM_REQUESTERS-1:0]                          o_done,
    output logic [DATA_WIDTH-1:0]                              o_read_data,
    output rggen_status                                        o_status,
    output logic                                               bus_request,
    output rggen_direction                                     bus_direction,
    output logic [LOCAL_ADDRESS_WIDTH-1:0]                     bus_address,
    output logic [DATA_WIDTH-1:0]                              bus_write_data,
    output logic [DATA_WIDTH/8-1:0]                            bus_write_strobe,
    input  logic                                               bus_done,
    input  logic [DATA_WIDTH-1:0]                              bus_read_data,
    input  rggen_status                                        bus_status
);

    localparam int INDEX_WIDTH  = rggen_clog2_min1(NUM_REQUESTERS);
    localparam int STROBE_WIDTH = DATA_WIDTH / 8;
    localparam int COUNT_WIDTH  = rggen_clog2_min1(TIMEOUT_CYCLES + 1);
    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_BUSY = 1'b1;

    logic [0:0]               state_reg;
    logic [INDEX_WIDTH-1:0]   grant_reg;
    logic [INDEX_WIDTH-1:0]   pointer_reg;
    logic [INDEX_WIDTH-1:0]   pointer_next;
    rggen_direction           direction_reg;
    logic [LOCAL_ADDRESS_WIDTH-1:0] address_reg;
    logic [DATA_WIDTH-1:0]    write_data_reg;
    logic [STROBE_WIDTH-1:0]  write_strobe_reg;

    logic                      arb_valid;
    logic [NUM_REQUESTERS-1:0] arb_onehot;
    logic [INDEX_WIDTH-1:0]    arb_index;
    rggen_direction            selected_direction;
    logic [LOCAL_ADDRESS_WIDTH-1:0] selected_address;
    logic [DATA_WIDTH-1:0]     selected_write_data;
    logic [STROBE_WIDTH-1:0]   selected_write_strobe;
    logic                      timeout_hit;
    logic                      finish;

    rggen_round_robin_arbiter #(
        .NUM_REQUESTERS (NUM_REQUESTERS),
        .INDEX_WIDTH    (INDEX_WIDTH)
    ) u_round_robin (
        .request      (i_request),
        .pointer      (pointer_reg),
        .grant_valid  (arb_valid),
        .grant_onehot (arb_onehot),
        .grant_index  (arb_index)
    );

    always_comb begin
        selected_direction    = RGGEN_READ;
        selected_address      = '0;
        selected_write_data   = '0;
        selected_write_strobe = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (arb_onehot[i]) begin
                selected_direction    = i_direction[i];
                selected_address      = i_address[i];
                selected_write_data   = i_write_data[i];
                selected_write_strobe = i_write_strobe[i];
            end
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_watchdog
            logic [COUNT_WIDTH-1:0] count_reg;
            // Held at zero while idle, so every access starts counting from 0.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else if (state_reg == STATE_IDLE) begin
                    count_reg <= '0;
                end else begin
                    count_reg <= count_reg + COUNT_WIDTH'(1);
                end
            end
            assign timeout_hit = (state_reg == STATE_BUSY) && !bus_done &&
                                 (count_reg == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_watchdog
            assign timeout_hit = 1'b0;
        end
    endgenerate

    assign finish       = (state_reg == STATE_BUSY) && (bus_done || timeout_hit);
    assign pointer_next = (grant_reg == INDEX_WIDTH'(NUM_REQUESTERS - 1)) ? '0
                                                                          : grant_reg + INDEX_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= STATE_IDLE;
            grant_reg        <= '0;
            pointer_reg      <= '0;
            direction_reg    <= RGGEN_READ;
            address_reg      <= '0;
            write_data_reg   <= '0;
            write_strobe_reg <= '0;
        end else if (state_reg == STATE_IDLE) begin
            if (arb_valid) begin
                state_reg        <= STATE_BUSY;
                grant_reg        <= arb_index;
                direction_reg    <= selected_direction;
                address_reg      <= selected_address;
                write_data_reg   <= selected_write_data;
                write_strobe_reg <= selected_write_strobe;
            end
        end else if (finish) begin
            state_reg   <= STATE_IDLE;
            pointer_reg <= pointer_next;
        end
    end

    assign bus_request      = (state_reg == STATE_BUSY);
    assign bus_direction    = direction_reg;
    assign bus_address      = address_reg;
    assign bus_write_data   = write_data_reg;
    assign bus_write_strobe = write_strobe_reg;

    // A real bus_done always beats the watchdog in the same cycle.
    always_comb begin
        o_done      = '0;
        o_read_data = '0;
        o_status    = RGGEN_OKAY;
        if (finish) begin
            o_done[grant_reg] = 1'b1;
            if (bus_done) begin
                o_read_data = bus_read_data;
                o_status    = bus_status;
            end else begin
                o_status = RGGEN_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Bench for rggen_bus_arbiter: directed scenarios with literal expectations, then
// randomized requesters and a random-latency responder checked against a transaction-level model.
module tb_rggen_bus_arbiter;
    import rggen_rtl_pkg::*;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]          i_request;
    rggen_direction [N-1:0] i_direction;
    logic [N-1:0][AW-1:0]  i_address;
    logic [N-1:0][DW-1:0]  i_write_data;
    logic [N-1:0][SW-1:0]  i_write_strobe;
    logic [N-1:0]          o_done;
    logic [DW-1:0]         o_read_data;
    rggen_status           o_status;
    logic                  bus_request;
    rggen_direction        bus_direction;
    logic [AW-1:0]         bus_address;
    logic [DW-1:0]         bus_write_data;
    logic [SW-1:0]         bus_write_strobe;
    logic                  bus_done;
    logic [DW-1:0]         bus_read_data;
    rggen_status           bus_status;

    always #5 clk = ~clk;

    rggen_bus_arbiter #(
        .NUM_REQUESTERS      (N),
        .LOCAL_ADDRESS_WIDTH (AW),
        .DATA_WIDTH          (DW),
        .TIMEOUT_CYCLES      (TO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_request        (i_request),
        .i_direction      (i_direction),
        .i_address        (i_address),
        .i_write_data     (i_write_data),
        .i_write_strobe   (i_write_strobe),
        .o_done           (o_done),
        .o_read_data      (o_read_data),
        .o_status         (o_status),
        .bus_request      (bus_request),
        .bus_direction    (bus_direction),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_write_strobe (bus_write_strobe),
        .bus_done         (bus_done),
        .bus_read_data    (bus_read_data),
        .bus_status       (bus_status)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: who owns the bus, for how long, and the rotation pointer.
    int             m_owner = -1;
    int             m_ptr   = 0;
    int             m_age   = 0;
    int             txn_count = 0;
    rggen_direction m_dir   = RGGEN_READ;
    logic [AW-1:0]  m_addr  = '0;
    logic [DW-1:0]  m_wdata = '0;
    logic [SW-1:0]  m_strb  = '0;
    logic [N-1:0]   last_done = '0;

    always @(negedge clk) begin
        logic [N-1:0]  e_done;
        logic [DW-1:0] e_rdata;
        rggen_status   e_status;
        bit            fin_normal;
        bit            fin_timeout;
        bit            found;
        int            cand;
        if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_age = 0;
            m_dir = RGGEN_READ; m_addr = '0; m_wdata = '0; m_strb = '0;
            last_done = '0;
            chk("reset_bus_request", bus_request, 0);
            chk("reset_o_done", o_done, 0);
            chk("reset_o_read_data", o_read_data, 0);
            chk("reset_o_status", o_status, RGGEN_OKAY);
            chk("reset_bus_direction", bus_direction, RGGEN_READ);
            chk("reset_bus_address", bus_address, 0);
            chk("reset_bus_write_data", bus_write_data, 0);
            chk("reset_bus_write_strobe", bus_write_strobe, 0);
        end else begin
            e_done = '0; e_rdata = '0; e_status = RGGEN_OKAY;
            fin_normal = 0; fin_timeout = 0;
            if (m_owner >= 0) begin
                fin_normal  = bus_done;
                fin_timeout = !bus_done && (m_age == TO - 1);
                if (fin_normal || fin_timeout) e_done[m_owner] = 1'b1;
                if (fin_normal) begin
                    e_rdata  = bus_read_data;
                    e_status = bus_status;
                end else if (fin_timeout) begin
                    e_status = RGGEN_SLVERR;
                end
                chk("model_bus_direction", bus_direction, m_dir);
                chk("model_bus_address", bus_address, m_addr);
                chk("model_bus_write_data", bus_write_data, m_wdata);
                chk("model_bus_write_strobe", bus_write_strobe, m_strb);
            end
            chk("model_bus_request", bus_request, (m_owner >= 0));
            chk("model_o_done", o_done, e_done);
            chk("model_o_read_data", o_read_data, e_rdata);
            chk("model_o_status", o_status, e_status);
            last_done = o_done;
            if (m_owner >= 0) begin
                if (fin_normal || fin_timeout) begin
                    txn_count++;
                    $display("txn %0d: requester %0d %s addr 0x%h %s status %0d rdata 0x%h",
                             txn_count, m_owner, (m_dir == RGGEN_WRITE) ? "write" : "read",
                             m_addr, fin_normal ? "done" : "timeout", e_status, e_rdata);
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end else begin
                    m_age++;
                end
            end else begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    cand = (m_ptr + k) % N;
                    if (!found && i_request[cand]) begin
                        found   = 1;
                        m_owner = cand;
                        m_age   = 0;
                        m_dir   = i_direction[cand];
                        m_addr  = i_address[cand];
                        m_wdata = i_write_data[cand];
                        m_strb  = i_write_strobe[cand];
                    end
                end
            end
        end
    end

    // Wait for the grant, answer after 'delay' extra cycles, check the response, then retire the request.
    task automatic serve(input int g, input logic [AW-1:0] a, input int delay,
                         input rggen_status st, input logic [DW-1:0] rd, input bit rearm);
        int n = 0;
        while (bus_request !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("serve_grant_within_bound", (n < 20), 1);
        chk("serve_bus_address", bus_address, a);
        repeat (delay) step();
        bus_done = 1'b1; bus_status = st; bus_read_data = rd;
        @(negedge clk);
        chk("serve_o_done", o_done, 1 << g);
        chk("serve_o_status", o_status, st);
        chk("serve_o_read_data", o_read_data, rd);
        step();
        bus_done = 1'b0; bus_status = RGGEN_OKAY; bus_read_data = '0;
        i_request[g] = 1'b0;
        step();
        i_request[g] = rearm;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit s_active = 0;
        int s_wait = 0;
        i_request = '0; i_direction = '{default: RGGEN_READ};
        i_address = '0; i_write_data = '0; i_write_strobe = '0;
        bus_done = 1'b0; bus_read_data = '0; bus_status = RGGEN_OKAY;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single write from requester 0, answered on the 3rd BUSY cycle.
        i_direction[0] = RGGEN_WRITE; i_address[0] = 16'h0010;
        i_write_data[0] = 32'hA5A5_0001; i_write_strobe[0] = 4'hF; i_request[0] = 1'b1;
        step();
        @(negedge clk);
        chk("t1_bus_request", bus_request, 1);
        chk("t1_bus_direction", bus_direction, RGGEN_WRITE);
        chk("t1_bus_address", bus_address, 16'h0010);
        chk("t1_bus_write_data", bus_write_data, 32'hA5A5_0001);
        chk("t1_bus_write_strobe", bus_write_strobe, 4'hF);
        step(); step();
        bus_done = 1'b1; bus_status = RGGEN_OKAY; bus_read_data = '0;
        @(negedge clk);
        chk("t1_o_done", o_done, 2'b01);
        chk("t1_o_status", o_status, RGGEN_OKAY);
        step();
        bus_done = 1'b0; i_request[0] = 1'b0;
        @(negedge clk);
        chk("t1_bus_request_drop", bus_request, 0);
        step();

        // Read from requester 1 with SLVERR response.
        i_direction[1] = RGGEN_READ; i_address[1] = 16'h0020; i_request[1] = 1'b1;
        serve(1, 16'h0020, 1, RGGEN_SLVERR, 32'hDEAD_BEEF, 0);

        // Both requesting: strict alternation 0,1,0,1 then 0.
        i_direction[0] = RGGEN_WRITE; i_address[0] = 16'h0040;
        i_write_data[0] = 32'h4040_4040; i_write_strobe[0] = 4'h3;
        i_direction[1] = RGGEN_READ; i_address[1] = 16'h0080;
        i_request = 2'b11;
        serve(0, 16'h0040, 2, RGGEN_OKAY,   32'h0000_0001, 1);
        serve(1, 16'h0080, 1, RGGEN_OKAY,   32'h0000_0002, 1);
        serve(0, 16'h0040, 0, RGGEN_EXOKAY, 32'h0000_0003, 1);
        serve(1, 16'h0080, 3, RGGEN_DECERR, 32'h0000_0004, 0);
        serve(0, 16'h0040, 1, RGGEN_OKAY,   32'h0000_0005, 0);

        // Watchdog: no bus_done, response forced on the 8th BUSY cycle.
        bus_read_data = 32'hFFFF_FFFF;
        i_request[0] = 1'b1;
        step();
        @(negedge clk);
        chk("t4_bus_request", bus_request, 1);
        repeat (6) step();
        @(negedge clk);
        chk("t4_no_done_cycle7", o_done, 2'b00);
        step();
        @(negedge clk);
        chk("t4_timeout_o_done", o_done, 2'b01);
        chk("t4_timeout_o_status", o_status, RGGEN_SLVERR);
        chk("t4_timeout_o_read_data", o_read_data, 0);
        step();
        i_request[0] = 1'b0; bus_read_data = '0;
        @(negedge clk);
        chk("t4_bus_request_drop", bus_request, 0);
        step();
        i_request[1] = 1'b1;
        serve(1, 16'h0080, 1, RGGEN_OKAY, 32'h0000_0006, 0);

        // bus_done in the same cycle the watchdog would fire: normal response wins.
        i_request[0] = 1'b1;
        step();
        repeat (7) step();
        bus_done = 1'b1; bus_status = RGGEN_OKAY; bus_read_data = 32'h1234_5678;
        @(negedge clk);
        chk("t5_o_done", o_done, 2'b01);
        chk("t5_o_status", o_status, RGGEN_OKAY);
        chk("t5_o_read_data", o_read_data, 32'h1234_5678);
        step();
        bus_done = 1'b0; bus_read_data = '0; i_request[0] = 1'b0;
        step();

        // Reset while BUSY for requester 1: outputs return to reset values immediately.
        i_request[1] = 1'b1;
        step(); step();
        #1 rst_n = 1'b0;
        bus_done = 1'b1; bus_status = RGGEN_SLVERR; bus_read_data = 32'h0000_0BAD;
        #1;
        chk("t6_async_bus_request", bus_request, 0);
        chk("t6_async_o_done", o_done, 0);
        chk("t6_async_o_status", o_status, RGGEN_OKAY);
        chk("t6_async_o_read_data", o_read_data, 0);
        chk("t6_async_bus_address", bus_address, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus_done = 1'b0; bus_status = RGGEN_OKAY; bus_read_data = '0;
        i_request[0] = 1'b1;
        serve(0, 16'h0040, 1, RGGEN_OKAY, 32'h0000_0007, 0);
        serve(1, 16'h0080, 1, RGGEN_OKAY, 32'h0000_0008, 0);

        // Randomized requesters and responder, checked by the model on every cycle.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            bus_done = 1'b0; bus_read_data = '0; bus_status = RGGEN_OKAY;
            if (bus_request) begin
                if (!s_active) begin
                    s_active = 1;
                    s_wait = $urandom_range(0, 10);
                end
                if (s_wait == 0) begin
                    bus_done      = 1'b1;
                    bus_read_data = $urandom;
                    bus_status    = rggen_status'($urandom_range(0, 3));
                    s_active      = 0;
                end else begin
                    s_wait--;
                end
            end else begin
                s_active = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (i_request[i]) begin
                    if (last_done[i]) i_request[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    i_direction[i]    = rggen_direction'($urandom_range(0, 1));
                    i_address[i]      = AW'($urandom);
                    i_write_data[i]   = $urandom;
                    i_write_strobe[i] = SW'($urandom_range(0, 15));
                    i_request[i]      = 1'b1;
                end
            end
            if (cyc == 1500) begin
                #2 rst_n = 1'b0;
                bus_done = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                s_active = 0;
            end
        end
        i_request = '0;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
